// File: rtl/spi_subordinate_pkg.sv
// ----------------------------------------------------------------------------
// spi_subordinate_pkg
//   Shared constants for the SPI subordinate front end of the AES core.
//   DATA_OUT_DEFAULT is the frame width used when the instantiating level does
//   not override it (one 128-bit AES block per frame).
// ----------------------------------------------------------------------------
package spi_subordinate_pkg;

    // Default frame width: one full AES block per SPI frame.
    localparam int DATA_OUT_DEFAULT = 128;

endpackage : spi_subordinate_pkg

// File: rtl/spi_subordinate.sv
// ----------------------------------------------------------------------------
// spi_subordinate
//   SPI subordinate, mode 0 (CPOL=0, CPHA=0), MSB first, full duplex.
//   One DATA_OUT-bit word is shifted in on sdi while the parallel word tx is
//   shifted out on sdo in the same frame. The received word is presented on rx
//   with a level flag done once a frame completes.
//
// Ports
//   sclk   in   1         SPI clock, the only clock; state updates on rising edge
//   rst_n  in   1         asynchronous active-low reset
//   cs     in   1         chip select, active-low; high also clears the bit counter
//   sdi    in   1         serial data from the controller
//   sdo    out  1         serial data to the controller, high-Z while cs=1
//   tx     in   DATA_OUT  word to transmit, captured on the first edge of a frame
//   rx     out  DATA_OUT  last completely received word
//   done   out  1         a complete frame has been received into rx
// ----------------------------------------------------------------------------
module spi_subordinate
    import spi_subordinate_pkg::*;
#(
    parameter int DATA_OUT = DATA_OUT_DEFAULT
)
(
    input  logic                sclk,
    input  logic                rst_n,
    input  logic                cs,
    input  logic                sdi,
    output logic                sdo,
    input  logic [DATA_OUT-1:0] tx,
    output logic [DATA_OUT-1:0] rx,
    output logic                done
);

    localparam int                CNT_W    = $clog2(DATA_OUT);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_OUT - 1);

    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [CNT_W-1:0]    bit_cnt_next;
    // Only DATA_OUT-1 bits are kept: the oldest bit of a full word goes
    // straight from here into rx and is never needed in the shifter itself.
    logic [DATA_OUT-2:0] rx_shift_reg;
    logic [DATA_OUT-2:0] rx_shift_next;
    logic [DATA_OUT-1:0] tx_shift_reg;
    logic [DATA_OUT-1:0] tx_shift_next;
    logic [DATA_OUT-1:0] rx_reg;
    logic [DATA_OUT-1:0] rx_next;
    logic                done_reg;
    logic                done_next;

    logic [DATA_OUT-1:0] rx_word;
    logic                frame_first;
    logic                frame_last;
    logic                cnt_clr_n;

    assign frame_first = (bit_cnt_reg == '0);
    assign frame_last  = (bit_cnt_reg == LAST_BIT);

    // Word as it will look once the current sdi bit is shifted in.
    assign rx_word = {rx_shift_reg, sdi};

    // Deselecting the subordinate must abandon a partial frame at once, even
    // with sclk parked, so cs joins rst_n as an asynchronous counter clear.
    assign cnt_clr_n = rst_n & ~cs;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        bit_cnt_next  = frame_last ? '0 : bit_cnt_reg + 1'b1;
        rx_shift_next = rx_word[DATA_OUT-2:0];
        // tx is sampled only on the first edge of a frame, so changes to tx
        // during a frame cannot disturb the word being sent.
        tx_shift_next = frame_first ? (tx << 1) : (tx_shift_reg << 1);
        rx_next       = rx_reg;
        done_next     = done_reg;
        if (frame_last) begin
            rx_next   = rx_word;
            done_next = 1'b1;
        end else if (frame_first) begin
            done_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge sclk or negedge cnt_clr_n) begin
        if (!cnt_clr_n) begin
            bit_cnt_reg <= '0;
        end else begin
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Shift registers and output registers; frozen while deselected
    // ------------------------------------------------------------------
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift_reg <= '0;
            tx_shift_reg <= '0;
            rx_reg       <= '0;
            done_reg     <= 1'b0;
        end else if (!cs) begin
            rx_shift_reg <= rx_shift_next;
            tx_shift_reg <= tx_shift_next;
            rx_reg       <= rx_next;
            done_reg     <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Before the first edge of a frame the shifter still holds old data, so
    // the first bit comes directly from tx.
    assign sdo  = cs ? 1'bz : (frame_first ? tx[DATA_OUT-1] : tx_shift_reg[DATA_OUT-1]);
    assign rx   = rx_reg;
    assign done = done_reg;

endmodule : spi_subordinate

// File: tb/tb_spi_subordinate.sv
// ----------------------------------------------------------------------------
// tb_spi_subordinate
//   Scoreboard bench for spi_subordinate: an 8-bit instance driven by directed
//   and random frames, plus a 128-bit instance for one full-width frame.
//   The driver pushes the expected received word and the expected transmitted
//   word of every complete frame into queues; monitors pop them when the DUT
//   raises done or when a full frame of sdo bits has been collected.
// ----------------------------------------------------------------------------
module tb_spi_subordinate;

    localparam int W  = 8;
    localparam int WW = 128;

    logic          sclk = 1'b0;
    logic          rst_n;
    logic          cs;
    logic          sdi;
    logic [W-1:0]  tx;
    wire           sdo;
    logic [W-1:0]  rx;
    logic          done;

    logic          cs_w;
    logic          sdi_w;
    logic [WW-1:0] tx_w;
    wire           sdo_w;
    logic [WW-1:0] rx_w;
    logic          done_w;

    int vectors = 0;
    int errors  = 0;

    logic [W-1:0]  exp_rx_q[$];
    logic [W-1:0]  exp_tx_q[$];
    logic [WW-1:0] exp_rx_w_q[$];
    logic [WW-1:0] exp_tx_w_q[$];

    spi_subordinate #(.DATA_OUT(W)) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .cs    (cs),
        .sdi   (sdi),
        .sdo   (sdo),
        .tx    (tx),
        .rx    (rx),
        .done  (done)
    );

    spi_subordinate #(.DATA_OUT(WW)) dut_w (
        .sclk  (sclk),
        .rst_n (rst_n),
        .cs    (cs_w),
        .sdi   (sdi_w),
        .sdo   (sdo_w),
        .tx    (tx_w),
        .rx    (rx_w),
        .done  (done_w)
    );

    always #5 sclk = ~sclk;

    task automatic check(input bit ok, input string name,
                         input logic [WW-1:0] act, input logic [WW-1:0] exp);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One frame on the 8-bit instance: nbits bits of d, MSB first. A frame of
    // W bits is complete and is expected on rx and on sdo; a shorter one is an
    // abort. tx is scrambled after the first bit since it must be ignored.
    task automatic send_frame(input logic [W-1:0] t, input logic [W-1:0] d,
                              input int nbits, input bit keep_low);
        if (nbits == W) begin
            exp_rx_q.push_back(d);
            exp_tx_q.push_back(t);
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge sclk);
            cs  = 1'b0;
            sdi = d[W-1-i];
            tx  = (i == 0) ? t : W'($urandom);
        end
        $display("frame tx=%h sdi=%h bits=%0d keep_low=%0d", t, d, nbits, keep_low);
        if (!keep_low) begin
            @(negedge sclk);
            cs  = 1'b1;
            sdi = 1'($urandom);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor, 8-bit instance. Samples 2 time units after each falling edge:
    // sdo then shows the bit the controller will take on the next rising
    // edge, and rx/done show the state after the previous rising edge.
    // ------------------------------------------------------------------
    logic [W-1:0] acc;
    int           nbit      = 0;
    logic         prev_done = 1'b0;
    logic [W-1:0] prev_rx   = '0;
    logic [W-1:0] exp_w8;

    always @(negedge sclk) begin
        #2;
        if (!rst_n || cs) begin
            nbit = 0;
            if (cs) check(sdo === 1'bz, "sdo_hiz", WW'(sdo), '0);
        end else begin
            // One rising edge of this frame has passed: done must be clear.
            if (nbit == 1) check(done === 1'b0, "done_clear", WW'(done), '0);
            acc  = {acc[W-2:0], sdo};
            nbit = nbit + 1;
            if (nbit == W) begin
                nbit = 0;
                if (exp_tx_q.size() == 0) begin
                    check(1'b0, "sdo_unexpected", WW'(acc), '0);
                end else begin
                    exp_w8 = exp_tx_q.pop_front();
                    check(acc === exp_w8, "sdo_word", WW'(acc), WW'(exp_w8));
                end
            end
        end
        if (rst_n) begin
            if (done === 1'b1 && prev_done !== 1'b1) begin
                if (exp_rx_q.size() == 0) begin
                    check(1'b0, "rx_unexpected", WW'(rx), '0);
                end else begin
                    exp_w8 = exp_rx_q.pop_front();
                    check(rx === exp_w8, "rx_word", WW'(rx), WW'(exp_w8));
                    $display("rx word %h (expected %h)", rx, exp_w8);
                end
            end else begin
                check(rx === prev_rx, "rx_hold", WW'(rx), WW'(prev_rx));
            end
        end
        prev_done = done;
        prev_rx   = rx;
    end

    // ------------------------------------------------------------------
    // Monitor, 128-bit instance.
    // ------------------------------------------------------------------
    logic [WW-1:0] acc_w;
    int            nbit_w      = 0;
    logic          prev_done_w = 1'b0;
    logic [WW-1:0] exp_ww;

    always @(negedge sclk) begin
        #2;
        if (!rst_n || cs_w) begin
            nbit_w = 0;
        end else begin
            acc_w  = {acc_w[WW-2:0], sdo_w};
            nbit_w = nbit_w + 1;
            if (nbit_w == WW) begin
                nbit_w = 0;
                if (exp_tx_w_q.size() == 0) begin
                    check(1'b0, "sdo_w_unexpected", acc_w, '0);
                end else begin
                    exp_ww = exp_tx_w_q.pop_front();
                    check(acc_w === exp_ww, "sdo_w_word", acc_w, exp_ww);
                end
            end
        end
        if (rst_n && done_w === 1'b1 && prev_done_w !== 1'b1) begin
            if (exp_rx_w_q.size() == 0) begin
                check(1'b0, "rx_w_unexpected", rx_w, '0);
            end else begin
                exp_ww = exp_rx_w_q.pop_front();
                check(rx_w === exp_ww, "rx_w_word", rx_w, exp_ww);
                $display("rx_w word %h", rx_w);
            end
        end
        prev_done_w = done_w;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [WW-1:0] tw;
        logic [WW-1:0] dw;
        int            nb;
        bit            kl;

        rst_n = 1'b1;
        cs    = 1'b1;
        sdi   = 1'b0;
        tx    = '0;
        cs_w  = 1'b1;
        sdi_w = 1'b0;
        tx_w  = '0;

        // Reset with cs high.
        #1 rst_n = 1'b0;
        #3;
        check(rx === 8'h00, "reset_rx", WW'(rx), '0);
        check(done === 1'b0, "reset_done", WW'(done), '0);
        check(sdo === 1'bz, "reset_sdo", WW'(sdo), '0);
        check(rx_w === '0, "reset_rx_w", rx_w, '0);
        @(negedge sclk);
        rst_n = 1'b1;
        @(negedge sclk);

        // Basic frame.
        send_frame(8'hA5, 8'h3C, W, 1'b0);

        // Back-to-back frames, cs low throughout.
        send_frame(8'h5E, 8'h3C, W, 1'b1);
        send_frame(8'hC3, 8'hF0, W, 1'b0);

        // Abort after 5 bits (rx must hold), then a full frame.
        send_frame(8'h3C, 8'h3C, W, 1'b0);
        send_frame(8'h77, 8'hE6, 5, 1'b0);
        #3;
        check(rx === 8'h3C, "abort_rx", WW'(rx), WW'(8'h3C));
        send_frame(8'h12, 8'h81, W, 1'b0);

        // Reset in the middle of a frame.
        send_frame(8'h99, 8'hB4, 3, 1'b1);
        @(negedge sclk);
        rst_n = 1'b0;
        cs    = 1'b1;
        #3;
        check(rx === 8'h00, "midreset_rx", WW'(rx), '0);
        check(done === 1'b0, "midreset_done", WW'(done), '0);
        @(negedge sclk);
        rst_n = 1'b1;
        send_frame(8'h6D, 8'h5A, W, 1'b0);

        // Random frames: full, back-to-back, aborted, with random idle gaps.
        repeat (40) begin
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : W;
            kl = (nb == W) && ($urandom_range(0, 1) == 1);
            send_frame(W'($urandom), W'($urandom), nb, kl);
            if (!kl) repeat ($urandom_range(0, 2)) @(negedge sclk);
        end
        @(negedge sclk);
        cs = 1'b1;

        // Full-width frame on the 128-bit instance.
        tw = 128'h00112233445566778899AABBCCDDEEFF;
        dw = 128'h0123456789ABCDEFFEDCBA9876543210;
        exp_rx_w_q.push_back(dw);
        exp_tx_w_q.push_back(tw);
        for (int i = 0; i < WW; i++) begin
            @(negedge sclk);
            cs_w  = 1'b0;
            sdi_w = dw[WW-1-i];
            tx_w  = (i == 0) ? tw : {4{32'($urandom)}};
        end
        @(negedge sclk);
        cs_w = 1'b1;
        #3;
        check(done_w === 1'b1, "done_w", WW'(done_w), WW'(1'b1));
        check(rx_w === dw, "rx_w_final", rx_w, dw);

        // Every queued expectation must have been consumed.
        repeat (3) @(negedge sclk);
        #4;
        check(exp_rx_q.size() == 0, "rx_q_drain", WW'(exp_rx_q.size()), '0);
        check(exp_tx_q.size() == 0, "tx_q_drain", WW'(exp_tx_q.size()), '0);
        check(exp_rx_w_q.size() == 0, "rx_w_q_drain", WW'(exp_rx_w_q.size()), '0);
        check(exp_tx_w_q.size() == 0, "tx_w_q_drain", WW'(exp_tx_w_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_spi_subordinate
